// File: rtl/kronos_id_queue.sv
// kronos_id_queue: RV32I decode stage feeding a DEPTH-entry queue of decoded
// instructions, with a pending-write scoreboard (x1..x31) so that queued
// instructions never capture stale operands.
// Optional feature macro: KRONOS_ID_M_EXT_EN (RV32M OP encodings decode as class 6).
// Handshakes (fetch_vld/fetch_rdy and decode_vld/decode_rdy): a transfer occurs on
// a rising clk edge where vld and rdy are both high; while vld & ~rdy the producer
// holds vld and its payload stable; rdy never depends on the same interface's vld.
module kronos_id_queue #(
   parameter int DEPTH               = 2,
   parameter int CATCH_ILLEGAL_INSTR = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] fetch_pc,
   input  logic [31:0] fetch_ir,
   input  logic [31:0] immediate,
   input  logic [31:0] regrd_rs1,
   input  logic [31:0] regrd_rs2,
   input  logic        fetch_vld,
   output logic        fetch_rdy,
   output logic [31:0] decode_pc,
   output logic [31:0] decode_ir,
   output logic [31:0] decode_op1,
   output logic [31:0] decode_op2,
   output logic [3:0]  decode_aluop,
   output logic [2:0]  decode_class,
   output logic [4:0]  decode_rd,
   output logic        decode_illegal,
   output logic        decode_vld,
   input  logic        decode_rdy,
   input  logic [31:0] regwr_data,
   input  logic [4:0]  regwr_sel,
   input  logic        regwr_en
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [2:0] CLS_ALU    = 3'd0;
   localparam logic [2:0] CLS_JUMP   = 3'd1;
   localparam logic [2:0] CLS_BRANCH = 3'd2;
   localparam logic [2:0] CLS_LOAD   = 3'd3;
   localparam logic [2:0] CLS_STORE  = 3'd4;
   localparam logic [2:0] CLS_SYSTEM = 3'd5;
   localparam logic [2:0] CLS_MULDIV = 3'd6;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  aluop;
      logic [2:0]  cls;
      logic [4:0]  rd;
      logic        ill;
   } entry_t;

   entry_t        r_q [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [31:0]   r_pending;

   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic        w_fwd1;
   logic        w_fwd2;
   logic [31:0] w_rs1_data;
   logic [31:0] w_rs2_data;
   logic [31:0] w_op1;
   logic [31:0] w_op2;
   logic [3:0]  w_aluop;
   logic [2:0]  w_class;
   logic        w_wr_rd;
   logic        w_use1;
   logic        w_use2;
   logic        w_legal;
   logic [4:0]  w_rd;
   logic        w_hazard;
   logic        w_waw;
   logic        w_push;
   logic        w_pop;
   entry_t      w_entry;
   logic [31:0] w_pending_nxt;

   assign w_opcode = fetch_ir[6:0];
   assign w_f3     = fetch_ir[14:12];
   assign w_f7     = fetch_ir[31:25];
   assign w_rs1    = fetch_ir[19:15];
   assign w_rs2    = fetch_ir[24:20];

   // Writeback forwarding: a register being written this cycle is taken from the write port.
   assign w_fwd1     = regwr_en && (regwr_sel == w_rs1) && (w_rs1 != 5'd0);
   assign w_fwd2     = regwr_en && (regwr_sel == w_rs2) && (w_rs2 != 5'd0);
   assign w_rs1_data = w_fwd1 ? regwr_data : regrd_rs1;
   assign w_rs2_data = w_fwd2 ? regwr_data : regrd_rs2;

   // Instruction decode: operands, ALU op, class, register usage and legality.
   always_comb begin
      w_op1   = fetch_pc;
      w_op2   = 32'd4;
      w_aluop = 4'd0;
      w_class = CLS_ALU;
      w_wr_rd = 1'b0;
      w_use1  = 1'b0;
      w_use2  = 1'b0;
      w_legal = 1'b0;
      case (w_opcode)
         OPC_LUI: begin
            w_op1 = 32'd0; w_op2 = immediate; w_wr_rd = 1'b1; w_legal = 1'b1;
         end
         OPC_AUIPC: begin
            w_op2 = immediate; w_wr_rd = 1'b1; w_legal = 1'b1;
         end
         OPC_JAL: begin
            w_class = CLS_JUMP; w_wr_rd = 1'b1; w_legal = 1'b1;
         end
         OPC_JALR: begin
            w_class = CLS_JUMP; w_wr_rd = 1'b1; w_use1 = 1'b1;
            w_legal = (w_f3 == 3'b000);
         end
         OPC_BRANCH: begin
            w_class = CLS_BRANCH; w_op1 = w_rs1_data; w_op2 = w_rs2_data;
            w_use1 = 1'b1; w_use2 = 1'b1;
            w_legal = (w_f3[2:1] != 2'b01);
         end
         OPC_LOAD: begin
            w_class = CLS_LOAD; w_op1 = w_rs1_data; w_op2 = immediate;
            w_use1 = 1'b1; w_wr_rd = 1'b1;
            w_legal = (w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
         end
         OPC_STORE: begin
            w_class = CLS_STORE; w_op1 = w_rs1_data; w_op2 = w_rs2_data;
            w_use1 = 1'b1; w_use2 = 1'b1;
            w_legal = (w_f3 inside {3'b000, 3'b001, 3'b010});
         end
         OPC_OPIMM: begin
            w_op1 = w_rs1_data; w_op2 = immediate; w_use1 = 1'b1; w_wr_rd = 1'b1;
            if (w_f3 == 3'b001) begin
               w_aluop = {w_f7[5], w_f3};
               w_legal = (w_f7 == 7'h00);
            end else if (w_f3 == 3'b101) begin
               w_aluop = {w_f7[5], w_f3};
               w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
            end else begin
               w_aluop = {1'b0, w_f3};
               w_legal = 1'b1;
            end
         end
         OPC_OP: begin
            w_op1 = w_rs1_data; w_op2 = w_rs2_data;
            w_use1 = 1'b1; w_use2 = 1'b1; w_wr_rd = 1'b1;
            w_aluop = {w_f7[5], w_f3};
            w_legal = (w_f7 == 7'h00) ||
                      ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
`ifdef KRONOS_ID_M_EXT_EN
            if (w_f7 == 7'h01) begin
               w_class = CLS_MULDIV; w_aluop = {1'b0, w_f3}; w_legal = 1'b1;
            end
`endif
         end
         OPC_MISC_MEM: begin
            // FENCE and FENCE.I
            w_class = CLS_SYSTEM;
            w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001);
         end
         OPC_SYSTEM: begin
            w_class = CLS_SYSTEM;
            if (w_f3 == 3'b000) begin
               // ECALL, EBREAK, MRET, WFI are the only accepted privileged words
               w_legal = (fetch_ir == 32'h0000_0073) || (fetch_ir == 32'h0010_0073) ||
                         (fetch_ir == 32'h3020_0073) || (fetch_ir == 32'h1050_0073);
            end else if (w_f3 != 3'b100) begin
               // CSR access; only the register forms (funct3 001..011) read rs1
               w_wr_rd = 1'b1; w_use1 = ~w_f3[2]; w_legal = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign w_rd     = w_wr_rd ? fetch_ir[11:7] : 5'd0;
   assign w_hazard = (w_use1 && r_pending[w_rs1] && !w_fwd1) ||
                     (w_use2 && r_pending[w_rs2] && !w_fwd2);
   assign w_waw    = (w_rd != 5'd0) && r_pending[w_rd];
   assign w_pop    = decode_vld && decode_rdy;
   assign fetch_rdy = ((r_count < CNT_FULL) || w_pop) && !w_hazard && !w_waw && !flush;
   assign w_push   = fetch_vld && fetch_rdy;

   assign w_entry.pc    = fetch_pc;
   assign w_entry.ir    = fetch_ir;
   assign w_entry.op1   = w_op1;
   assign w_entry.op2   = w_op2;
   assign w_entry.aluop = w_aluop;
   assign w_entry.cls   = w_class;
   assign w_entry.rd    = w_rd;
   assign w_entry.ill   = (CATCH_ILLEGAL_INSTR != 0) && !w_legal;

   // Scoreboard next state: flush releases queued writers, writeback clears, enqueue sets (set wins).
   always_comb begin
      w_pending_nxt = r_pending;
      if (flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(r_count)) w_pending_nxt[r_q[r_rd_ptr + AW'(k)].rd] = 1'b0;
         end
      end
      if (regwr_en) w_pending_nxt[regwr_sel] = 1'b0;
      if (w_push)   w_pending_nxt[w_rd]      = 1'b1;
      w_pending_nxt[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) r_pending <= '0;
      else     r_pending <= w_pending_nxt;
   end

   // Queue storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      end else if (flush) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_q[r_wr_ptr] <= w_entry;
            r_wr_ptr      <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   assign decode_vld     = (r_count != '0);
   assign decode_pc      = r_q[r_rd_ptr].pc;
   assign decode_ir      = r_q[r_rd_ptr].ir;
   assign decode_op1     = r_q[r_rd_ptr].op1;
   assign decode_op2     = r_q[r_rd_ptr].op2;
   assign decode_aluop   = r_q[r_rd_ptr].aluop;
   assign decode_class   = r_q[r_rd_ptr].cls;
   assign decode_rd      = r_q[r_rd_ptr].rd;
   assign decode_illegal = r_q[r_rd_ptr].ill;

endmodule

// File: tb/tb_kronos_id_queue.sv
// tb_kronos_id_queue: randomized + directed bench for kronos_id_queue, with a
// behavioural reference model (queue, scoreboard bit array, in-EX list) and a
// decoupled monitor that checks every head entry against an expected queue.
module tb_kronos_id_queue;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] fetch_pc, fetch_ir, immediate, regrd_rs1, regrd_rs2;
  logic        fetch_vld, decode_rdy;
  logic [31:0] regwr_data;
  logic [4:0]  regwr_sel;
  logic        regwr_en;

  logic        fetch_rdy, decode_vld, decode_illegal;
  logic [31:0] decode_pc, decode_ir, decode_op1, decode_op2;
  logic [3:0]  decode_aluop;
  logic [2:0]  decode_class;
  logic [4:0]  decode_rd;

  logic        nc_fetch_rdy, nc_decode_vld, nc_decode_illegal;
  logic [31:0] nc_decode_pc, nc_decode_ir, nc_decode_op1, nc_decode_op2;
  logic [3:0]  nc_decode_aluop;
  logic [2:0]  nc_decode_class;
  logic [4:0]  nc_decode_rd;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  aluop;
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  logic [4:0]  ex_q[$];
  logic [31:0] m_pending;
  logic [31:0] pc_ctr;
  logic        mon_en;
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  kronos_id_queue #(.DEPTH(DEPTH), .CATCH_ILLEGAL_INSTR(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_pc(fetch_pc), .fetch_ir(fetch_ir), .immediate(immediate),
    .regrd_rs1(regrd_rs1), .regrd_rs2(regrd_rs2),
    .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy),
    .decode_pc(decode_pc), .decode_ir(decode_ir), .decode_op1(decode_op1), .decode_op2(decode_op2),
    .decode_aluop(decode_aluop), .decode_class(decode_class), .decode_rd(decode_rd),
    .decode_illegal(decode_illegal), .decode_vld(decode_vld), .decode_rdy(decode_rdy),
    .regwr_data(regwr_data), .regwr_sel(regwr_sel), .regwr_en(regwr_en)
  );

  kronos_id_queue #(.DEPTH(DEPTH), .CATCH_ILLEGAL_INSTR(0)) dut_nc (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_pc(fetch_pc), .fetch_ir(fetch_ir), .immediate(immediate),
    .regrd_rs1(regrd_rs1), .regrd_rs2(regrd_rs2),
    .fetch_vld(fetch_vld), .fetch_rdy(nc_fetch_rdy),
    .decode_pc(nc_decode_pc), .decode_ir(nc_decode_ir), .decode_op1(nc_decode_op1),
    .decode_op2(nc_decode_op2), .decode_aluop(nc_decode_aluop), .decode_class(nc_decode_class),
    .decode_rd(nc_decode_rd), .decode_illegal(nc_decode_illegal), .decode_vld(nc_decode_vld),
    .decode_rdy(decode_rdy),
    .regwr_data(regwr_data), .regwr_sel(regwr_sel), .regwr_en(regwr_en)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference decode, written straight from the RV32I encoding rules.
  function automatic exp_t ref_dec(input logic [31:0] ir, input logic [31:0] pc,
                                   input logic [31:0] imm, input logic [31:0] a,
                                   input logic [31:0] b, output logic u1, output logic u2);
    exp_t       e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       wr;
    f3 = ir[14:12];
    f7 = ir[31:25];
    wr = 1'b0;
    u1 = 1'b0;
    u2 = 1'b0;
    e.pc = pc; e.ir = ir; e.op1 = pc; e.op2 = 32'd4;
    e.aluop = 4'd0; e.cls = 3'd0; e.rd = 5'd0; e.ill = 1'b1;
    case (ir[6:0])
      7'h37: begin e.op1 = 32'd0; e.op2 = imm; wr = 1'b1; e.ill = 1'b0; end
      7'h17: begin e.op2 = imm; wr = 1'b1; e.ill = 1'b0; end
      7'h6f: begin e.cls = 3'd1; wr = 1'b1; e.ill = 1'b0; end
      7'h67: begin e.cls = 3'd1; wr = 1'b1; u1 = 1'b1; e.ill = (f3 != 3'd0); end
      7'h63: begin e.cls = 3'd2; e.op1 = a; e.op2 = b; u1 = 1'b1; u2 = 1'b1;
                   e.ill = (f3 == 3'd2) || (f3 == 3'd3); end
      7'h03: begin e.cls = 3'd3; e.op1 = a; e.op2 = imm; u1 = 1'b1; wr = 1'b1;
                   e.ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7); end
      7'h23: begin e.cls = 3'd4; e.op1 = a; e.op2 = b; u1 = 1'b1; u2 = 1'b1;
                   e.ill = (f3 > 3'd2); end
      7'h13: begin
        e.op1 = a; e.op2 = imm; u1 = 1'b1; wr = 1'b1;
        if (f3 == 3'd1)      begin e.aluop = {f7[5], f3}; e.ill = (f7 != 7'h00); end
        else if (f3 == 3'd5) begin e.aluop = {f7[5], f3}; e.ill = !((f7 == 7'h00) || (f7 == 7'h20)); end
        else                 begin e.aluop = {1'b0, f3}; e.ill = 1'b0; end
      end
      7'h33: begin
        e.op1 = a; e.op2 = b; u1 = 1'b1; u2 = 1'b1; wr = 1'b1;
        if (f7 == 7'h01) begin
          e.aluop = {1'b0, f3};
`ifdef KRONOS_ID_M_EXT_EN
          e.cls = 3'd6; e.ill = 1'b0;
`else
          e.ill = 1'b1;
`endif
        end else begin
          e.aluop = {f7[5], f3};
          e.ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
        end
      end
      7'h0f: begin e.cls = 3'd5; e.ill = (f3 > 3'd1); end
      7'h73: begin
        e.cls = 3'd5;
        if (f3 == 3'd0)
          e.ill = !((ir == 32'h00000073) || (ir == 32'h00100073) ||
                    (ir == 32'h30200073) || (ir == 32'h10500073));
        else if (f3 == 3'd4) e.ill = 1'b1;
        else begin wr = 1'b1; u1 = (f3 < 3'd4); e.ill = 1'b0; end
      end
      default: ;
    endcase
    if (wr) e.rd = ir[11:7];
    return e;
  endfunction

  // Driver: one cycle of stimulus; checks fetch_rdy and advances the reference model.
  task automatic step(input logic fv, input logic [31:0] ir, input logic [31:0] imm,
                      input logic [31:0] r1, input logic [31:0] r2, input logic drdy,
                      input logic fl, input logic wen, input logic [4:0] wsel,
                      input logic [31:0] wdata);
    exp_t        e;
    logic        u1, u2, f1, f2, hz, waw, pop, rdy, push;
    logic [31:0] a, b, np;
    @(negedge clk);
    fetch_vld = fv; fetch_ir = ir; immediate = imm; fetch_pc = pc_ctr;
    regrd_rs1 = r1; regrd_rs2 = r2; decode_rdy = drdy; flush = fl;
    regwr_en = wen; regwr_sel = wsel; regwr_data = wdata;
    #1;
    f1 = wen && (wsel == ir[19:15]) && (ir[19:15] != 5'd0);
    f2 = wen && (wsel == ir[24:20]) && (ir[24:20] != 5'd0);
    a = f1 ? wdata : r1;
    b = f2 ? wdata : r2;
    e = ref_dec(ir, pc_ctr, imm, a, b, u1, u2);
    hz  = (u1 && m_pending[ir[19:15]] && !f1) || (u2 && m_pending[ir[24:20]] && !f2);
    waw = (e.rd != 5'd0) && m_pending[e.rd];
    pop = drdy && (exp_q.size() != 0);
    rdy = ((exp_q.size() < DEPTH) || pop) && !hz && !waw && !fl;
    check("fetch_rdy", 32'(fetch_rdy), 32'(rdy));
    check("nc_fetch_rdy", 32'(nc_fetch_rdy), 32'(rdy));
    push = fv && rdy;
    np = m_pending;
    if (fl) foreach (exp_q[k]) np[exp_q[k].rd] = 1'b0;
    if (wen) begin
      np[wsel] = 1'b0;
      foreach (ex_q[k]) if (ex_q[k] == wsel) begin ex_q.delete(k); break; end
    end
    if (push) np[e.rd] = 1'b1;
    np[0] = 1'b0;
    if (pop && (exp_q[0].rd != 5'd0)) ex_q.push_back(exp_q[0].rd);
    @(posedge clk);
    #1;
    m_pending = np;
    pc_ctr = pc_ctr + 32'd4;
    if (fl) exp_q.delete();
    if (push) exp_q.push_back(e);
  endtask

  task automatic idle(input logic drdy);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, drdy, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  // Drain queue and retire everything in EX, bounded.
  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (exp_q.size() == 0 && ex_q.size() == 0) break;
      if (ex_q.size() != 0)
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, ex_q[0], $urandom);
      else
        idle(1'b1);
    end
    check("drained", 32'(exp_q.size() + ex_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] r;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    r   = $urandom;
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    case ($urandom_range(0, 13))
      0:  return {r[31:12], rd, 7'h37};
      1:  return {r[31:12], rd, 7'h17};
      2:  return {r[31:12], rd, 7'h6f};
      3:  return {r[31:20], rs1, (r[0] ? 3'd0 : f3), rd, 7'h67};
      4:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'h63};
      5:  return {r[31:20], rs1, f3, rd, 7'h03};
      6:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'h23};
      7, 8:   return {f7, rs2, rs1, f3, rd, 7'h13};
      9, 10:  return {f7, rs2, rs1, f3, rd, 7'h33};
      11: return {r[31:15], 3'($urandom_range(0, 2)), r[11:7], 7'h0f};
      12: begin
        case ($urandom_range(0, 5))
          0: return 32'h00000073;
          1: return 32'h00100073;
          2: return 32'h30200073;
          3: return 32'h10500073;
          default: return {r[31:20], rs1, f3, rd, 7'h73};
        endcase
      end
      default: return r;
    endcase
  endfunction

  // Monitor: compares the presented head entry with the expected queue, pops on transfer.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      check("decode_vld", 32'(decode_vld), 32'(exp_q.size() != 0));
      check("nc_decode_vld", 32'(nc_decode_vld), 32'(exp_q.size() != 0));
      if (decode_vld && exp_q.size() != 0) begin
        mon_e = exp_q[0];
        check("decode_pc", decode_pc, mon_e.pc);
        check("decode_ir", decode_ir, mon_e.ir);
        check("decode_op1", decode_op1, mon_e.op1);
        check("decode_op2", decode_op2, mon_e.op2);
        check("decode_aluop", 32'(decode_aluop), 32'(mon_e.aluop));
        check("decode_class", 32'(decode_class), 32'(mon_e.cls));
        check("decode_rd", 32'(decode_rd), 32'(mon_e.rd));
        check("decode_illegal", 32'(decode_illegal), 32'(mon_e.ill));
        check("nc_decode_illegal", 32'(nc_decode_illegal), 32'd0);
        check("nc_decode_op1", nc_decode_op1, mon_e.op1);
        check("nc_decode_class", 32'(nc_decode_class), 32'(mon_e.cls));
        if (decode_rdy) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [4:0]  wsel;
    logic        wen, fl, drdy;
    mon_en = 1'b0;
    m_pending = '0;
    pc_ctr = 32'h0000_1000;
    rst = 1'b1; flush = 1'b0; fetch_vld = 1'b0; decode_rdy = 1'b0;
    fetch_pc = '0; fetch_ir = '0; immediate = '0; regrd_rs1 = '0; regrd_rs2 = '0;
    regwr_en = 1'b0; regwr_sel = '0; regwr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_decode_vld", 32'(decode_vld), 32'd0);
    check("rst_fetch_rdy", 32'(fetch_rdy), 32'd1);
    check("rst_decode_pc", decode_pc, 32'd0);
    check("rst_decode_ir", decode_ir, 32'd0);
    check("rst_decode_op1", decode_op1, 32'd0);
    check("rst_decode_op2", decode_op2, 32'd0);
    check("rst_decode_misc", {19'd0, decode_aluop, decode_class, decode_rd, decode_illegal}, 32'd0);
    mon_en = 1'b1;

    // ADDI x1,x0,5 then dependent ADD x2,x1,x1; forwarded writeback releases it
    step(1'b1, 32'h00500093, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h00108133, 32'd0, 32'hdeadbeef, 32'hdeadbeef, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h00108133, 32'd0, 32'hdeadbeef, 32'hdeadbeef, 1'b1, 1'b0, 1'b1, 5'd1, 32'd5);
    drain();

    // Full queue back-pressure, then simultaneous pop and push at full
    step(1'b1, 32'h00100493, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h00100513, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h00100593, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h00100593, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    drain();

    // x5 in EX, x3/x4 queued, flush keeps only x5 pending
    step(1'b1, 32'h00100293, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    idle(1'b1);
    step(1'b1, 32'h00100193, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h00100213, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h00100313, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h004183b3, 32'd0, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h00028433, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h00028433, 32'd0, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55);
    drain();

    // MUL x0,x1,x2 and the all-zero word
    step(1'b1, 32'h02208033, 32'd0, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h00000000, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    drain();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      fl   = ($urandom_range(0, 49) == 0);
      drdy = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
      wen  = 1'b0;
      wsel = 5'd0;
      if (ex_q.size() != 0 && $urandom_range(0, 1) == 1) begin
        wen = 1'b1; wsel = ex_q[$urandom_range(0, ex_q.size() - 1)];
      end else if ($urandom_range(0, 9) == 0) begin
        wen = 1'b1; wsel = 5'($urandom_range(0, 31));
      end
      step(($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
           drdy, fl, wen, wsel, $urandom);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
